addsub_arbiter: RTL and testbench

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

---
 rtl/addsub_arbiter.sv | 96 +++++++++
 tb/tb_addsub_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin two-requester add/subtract unit with IDLE/EXEC/DONE result handshake.
// Define ADDSUB_ARB_STATS_EN to add saturating per-requester completion counters cnt0/cnt1.
module addsub_arbiter #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req0_op,
    input  logic             req1_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_ofl,
    output logic             res_id
`ifdef ADDSUB_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t           state;
    logic             prio;
    logic             own;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] sum;
    logic             ofl;
    logic             gnt0;
    logic             gnt1;
    // prio names the requester that wins the next contention
    always_comb begin
        gnt0 = rst_n && state == IDLE && req0_valid && (!req1_valid || !prio);
        gnt1 = rst_n && state == IDLE && req1_valid && (!req0_valid || prio);
        bx   = b ^ {WIDTH{op}};
        sum  = a + bx + WIDTH'(op);
        ofl  = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            prio      <= 1'b0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_ofl   <= 1'b0;
            res_id    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (gnt0 || gnt1) begin
                    a     <= gnt1 ? req1_a : req0_a;
                    b     <= gnt1 ? req1_b : req0_b;
                    op    <= gnt1 ? req1_op : req0_op;
                    own   <= gnt1;
                    prio  <= gnt0;
                    state <= EXEC;
                end
                EXEC: begin
                    res_sum   <= sum;
                    res_ofl   <= ofl;
                    res_id    <= own;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (res_ready) begin
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef ADDSUB_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (res_valid && res_ready) begin
            if (!res_id && cnt0 != '1) cnt0 <= cnt0 + 1'b1;
            if (res_id && cnt1 != '1) cnt1 <= cnt1 + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed self-checking bench for addsub_arbiter.
// Define ADDSUB_ARB_STATS_EN to also exercise the saturating counters (CNT_W=2).
module tb_addsub_arbiter;
    localparam int W = 5;
`ifdef ADDSUB_ARB_STATS_EN
    localparam int CW = 2;
`else
    localparam int CW = 8;
`endif
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0;
    logic         req1_valid = 1'b0;
    logic         req0_op = 1'b0;
    logic         req1_op = 1'b0;
    logic         res_ready = 1'b0;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;
    logic         req0_ready;
    logic         req1_ready;
    logic         res_valid;
    logic         res_ofl;
    logic         res_id;
    logic [W-1:0] res_sum;
`ifdef ADDSUB_ARB_STATS_EN
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;
`endif
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    addsub_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_ofl(res_ofl), .res_id(res_id)
`ifdef ADDSUB_ARB_STATS_EN
        , .cnt0(cnt0), .cnt1(cnt1)
`endif
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Accept, EXEC, DONE with res_ready high: one result every 3 cycles.
    task automatic run_op(input logic eid, input logic [W-1:0] esum, input logic eofl, input string nm);
        logic [1:0] eg;
        eg = eid ? 2'b10 : 2'b01;
        #1;
        total++;
        if ({req1_ready, req0_ready} !== eg)
            $display("FAIL %s grant: ready=%b expected %b", nm, {req1_ready, req0_ready}, eg);
        else passed++;
        step;
        total++;
        if ({res_valid, req1_ready, req0_ready} !== 3'b000)
            $display("FAIL %s exec: valid,ready=%b expected 000", nm, {res_valid, req1_ready, req0_ready});
        else passed++;
        step;
        total++;
        if ({res_valid, res_id, res_ofl, res_sum} !== {1'b1, eid, eofl, esum})
            $display("FAIL %s result: valid=%b id=%b ofl=%b sum=%0d expected 1 %b %b %0d",
                     nm, res_valid, res_id, res_ofl, res_sum, eid, eofl, esum);
        else passed++;
        step;
        total++;
        if (res_valid !== 1'b0)
            $display("FAIL %s release: res_valid=%b expected 0", nm, res_valid);
        else passed++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        res_ready = 1'b0;
        step;
        step;
        total++;
        if ({req1_ready, req0_ready} !== 2'b00)
            $display("FAIL reset ready: %b expected 00", {req1_ready, req0_ready});
        else passed++;
        total++;
        if ({res_valid, res_id, res_ofl, res_sum} !== '0)
            $display("FAIL reset outputs: valid=%b id=%b ofl=%b sum=%0d expected all 0",
                     res_valid, res_id, res_ofl, res_sum);
        else passed++;
`ifdef ADDSUB_ARB_STATS_EN
        total++;
        if ({cnt1, cnt0} !== '0)
            $display("FAIL reset counters: cnt0=%0d cnt1=%0d expected 0 0", cnt0, cnt1);
        else passed++;
`endif
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_single;
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 5'd15; req0_b = 5'd2; req0_op = 1'b0;
        run_op(1'b0, 5'd17, 1'b1, "req0_add");
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 5'd3; req1_b = 5'd5; req1_op = 1'b1;
        run_op(1'b1, 5'd30, 1'b0, "req1_sub");
        req1_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        req0_valid = 1'b1; req0_a = 5'b01111; req0_b = 5'b10001; req0_op = 1'b0;
        req1_valid = 1'b1; req1_a = 5'b10000; req1_b = 5'd1;     req1_op = 1'b1;
        run_op(1'b0, 5'd0, 1'b0, "rr_0");
        run_op(1'b1, 5'd15, 1'b1, "rr_1");
        run_op(1'b0, 5'd0, 1'b0, "rr_2");
        run_op(1'b1, 5'd15, 1'b1, "rr_3");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_stall;
        req0_valid = 1'b1; req0_a = 5'b10000; req0_b = 5'b11111; req0_op = 1'b0;
        req1_valid = 1'b1;
        res_ready = 1'b0;
        #1;
        total++;
        if ({req1_ready, req0_ready} !== 2'b01)
            $display("FAIL stall grant: ready=%b expected 01", {req1_ready, req0_ready});
        else passed++;
        step;
        step;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({res_valid, res_id, res_ofl, res_sum, req1_ready, req0_ready} !== {1'b1, 1'b0, 1'b1, 5'd15, 2'b00})
                $display("FAIL stall hold %0d: valid=%b id=%b ofl=%b sum=%0d ready=%b expected 1 0 1 15 00",
                         i, res_valid, res_id, res_ofl, res_sum, {req1_ready, req0_ready});
            else passed++;
            step;
        end
        res_ready = 1'b1;
        step;
        total++;
        if (res_valid !== 1'b0)
            $display("FAIL stall release: res_valid=%b expected 0", res_valid);
        else passed++;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset_exec;
        req0_valid = 1'b1; req0_a = 5'd1; req0_b = 5'd1; req0_op = 1'b0;
        #1;
        total++;
        if (req0_ready !== 1'b1)
            $display("FAIL rst_exec grant: req0_ready=%b expected 1", req0_ready);
        else passed++;
        step;
        req0_valid = 1'b0;
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        total++;
        if ({res_valid, res_sum} !== '0)
            $display("FAIL rst_exec flush: valid=%b sum=%0d expected 0 0", res_valid, res_sum);
        else passed++;
        step;
        total++;
        if (res_valid !== 1'b0)
            $display("FAIL rst_exec no_result: res_valid=%b expected 0", res_valid);
        else passed++;
        req0_valid = 1'b1;
        req1_valid = 1'b1; req1_a = 5'd9; req1_b = 5'd9; req1_op = 1'b0;
        run_op(1'b0, 5'd2, 1'b0, "rst_exec_next");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

`ifdef ADDSUB_ARB_STATS_EN
    task automatic test_stats;
        test_reset;
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 5'd1; req0_b = 5'd0; req0_op = 1'b0;
        for (int i = 0; i < 5; i++) run_op(1'b0, 5'd1, 1'b0, "stats_op");
        req0_valid = 1'b0;
        total++;
        if ({cnt0, cnt1} !== {2'd3, 2'd0})
            $display("FAIL stats: cnt0=%0d cnt1=%0d expected 3 0", cnt0, cnt1);
        else passed++;
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_stall;
        test_reset_exec;
`ifdef ADDSUB_ARB_STATS_EN
        test_stats;
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
